// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources (A = ALU, B = load unit),
// the arbiter and the regfile write port.
interface regfile_wb_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   // Source side: the writeback producers plus anyone observing the regfile port.
   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      input  a_ready, b_ready, wr_en, wr_addr, wr_data
   );

   // Arbiter side.
   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      output a_ready, b_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source regfile writeback arbiter (B priority, A starvation guard) with a
// busy-register scoreboard. Define REGFILE_BYPASS_EN to add write-port forwarding.
module regfile_wb_arbiter #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int NREG       = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_en,
   input  logic [ADDR_W-1:0] alloc_addr,
   input  logic [ADDR_W-1:0] rd1_addr,
   input  logic [ADDR_W-1:0] rd2_addr,
   output logic              rd1_busy,
   output logic              rd2_busy,
   output logic [NREG-1:0]   busy_vec,
`ifdef REGFILE_BYPASS_EN
   output logic              rd1_fwd,
   output logic              rd2_fwd,
   output logic [DATA_W-1:0] fwd_data,
`endif
   regfile_wb_arbiter_if.slave wb
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
   logic [NREG-1:0]   busy_reg, busy_next;
   logic              wr_en_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic [DATA_W-1:0] wr_data_reg;

   logic              a_starved;
   logic              a_grant, b_grant, grant;
   logic [ADDR_W-1:0] grant_addr;
   logic [DATA_W-1:0] grant_data;

   always_comb begin
      a_starved       = (starve_cnt_reg == CNT_W'(STARVE_MAX));
      b_grant         = wb.b_valid && !(wb.a_valid && a_starved);
      a_grant         = wb.a_valid && !b_grant;
      grant           = a_grant || b_grant;
      grant_addr      = b_grant ? wb.b_addr : wb.a_addr;
      grant_data      = b_grant ? wb.b_data : wb.a_data;
      starve_cnt_next = '0;
      if (wb.a_valid && !a_grant)
         starve_cnt_next = a_starved ? starve_cnt_reg : starve_cnt_reg + 1'b1;
   end

   // Ready is forced low while reset is asserted so nothing is accepted and lost.
   assign wb.a_ready = rst && a_grant;
   assign wb.b_ready = rst && b_grant;

   // An alloc in the same cycle as a clear wins: a newer producer is outstanding.
   // x0 is never tracked.
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
         if (gi == 0) begin : g_x0
            assign busy_next[gi] = 1'b0;
         end else begin : g_xn
            assign busy_next[gi] =
               (alloc_en && (alloc_addr == ADDR_W'(gi))) ||
               (busy_reg[gi] && !(grant && (grant_addr == ADDR_W'(gi))));
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_reg <= '0;
         busy_reg       <= '0;
         wr_en_reg      <= 1'b0;
         wr_addr_reg    <= '0;
         wr_data_reg    <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
         busy_reg       <= busy_next;
         wr_en_reg      <= grant && (grant_addr != '0);
         if (grant) begin
            wr_addr_reg <= grant_addr;
            wr_data_reg <= grant_data;
         end
      end
   end

   assign wb.wr_en   = wr_en_reg;
   assign wb.wr_addr = wr_addr_reg;
   assign wb.wr_data = wr_data_reg;
   assign busy_vec   = busy_reg;

   logic rd1_sb, rd2_sb;
   assign rd1_sb = busy_reg[rd1_addr];
   assign rd2_sb = busy_reg[rd2_addr];

`ifdef REGFILE_BYPASS_EN
   // A source being written this cycle is readable from the port, so it is not a stall.
   assign rd1_fwd  = wr_en_reg && (wr_addr_reg == rd1_addr) && (rd1_addr != '0);
   assign rd2_fwd  = wr_en_reg && (wr_addr_reg == rd2_addr) && (rd2_addr != '0);
   assign fwd_data = wr_data_reg;
   assign rd1_busy = rd1_sb && !rd1_fwd;
   assign rd2_busy = rd2_sb && !rd2_fwd;
`else
   assign rd1_busy = rd1_sb;
   assign rd2_busy = rd2_sb;
`endif
endmodule
